// File: rtl/ingress_stage.sv
// ingress_stage: input end of the stc0 datapath.
// Pairs consecutive words from a valid/ready stream into operands A/B and
// hosts one slot of the daisy-chained control bus.
//
// Handshake: a word transfers on a rising Clk edge where IngressValid and
// IngressReady are both 1. IngressReady depends only on the stored INPUTEN
// bit, never on IngressValid. The pair output has no backpressure: ABValid
// is a one-cycle strobe and the consumer must take A/B in that cycle.

`ifndef CTRLWRD_SZ
`define CTRLWRD_SZ 32
`endif
`ifndef RB_INGRESSCTRL_INPUTEN
`define RB_INGRESSCTRL_INPUTEN 0
`endif
`ifndef RB_INGRESSCTRL_ORDER
`define RB_INGRESSCTRL_ORDER 1
`endif
`ifndef RB_INGRESSCTRL_DUP
`define RB_INGRESSCTRL_DUP 2
`endif
`ifndef RB_INGRESSCTRL_FLUSH
`define RB_INGRESSCTRL_FLUSH 3
`endif

module ingress_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_STAGE = 0
) (
  input  logic                       Clk,
  input  logic                       ARst,
  input  logic [3:0]                 CtrlAddr,
  input  logic [`CTRLWRD_SZ-1:0]     CtrlWord,
  input  logic                       CtrlValid,
  output logic [3:0]                 CtrlAddrOut,
  output logic [`CTRLWRD_SZ-1:0]     CtrlWordOut,
  output logic                       CtrlValidOut,
  input  logic [DATA_WIDTH*2-1:0]    IngressData,
  input  logic                       IngressValid,
  output logic                       IngressReady,
  output logic [DATA_WIDTH*2-1:0]    A,
  output logic [DATA_WIDTH*2-1:0]    B,
  output logic                       ABValid,
  output logic [15:0]                PairCount
);

  localparam int W = DATA_WIDTH * 2;
  localparam logic [3:0] STAGE_ADDR = 4'(CTRL_STAGE);

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [`CTRLWRD_SZ-1:0]  ctrl_q;
  logic [W-1:0]            hold_q, hold_d;
  logic [W-1:0]            a_q, a_d;
  logic [W-1:0]            b_q, b_d;
  logic                    abvalid_q, abvalid_d;
  logic [15:0]             count_q;
  logic [3:0]              fwd_addr_q;
  logic [`CTRLWRD_SZ-1:0]  fwd_word_q;
  logic                    fwd_valid_q;

  logic ctrl_match;
  logic flush;
  logic accept;
  logic unused_ctrl_bits;

  assign ctrl_match = CtrlValid && (CtrlAddr == STAGE_ADDR);
  // FLUSH acts straight from the bus word during a matching write.
  assign flush      = ctrl_match && CtrlWord[`RB_INGRESSCTRL_FLUSH];
  assign accept     = IngressValid && ctrl_q[`RB_INGRESSCTRL_INPUTEN];

  // Only the low control fields are decoded; the rest is simply stored.
  assign unused_ctrl_bits = ^ctrl_q;

  // Control slot: keep our word, forward everyone else's with a 1-cycle strobe.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      ctrl_q      <= '0;
      fwd_addr_q  <= '0;
      fwd_word_q  <= '0;
      fwd_valid_q <= 1'b0;
    end else begin
      fwd_valid_q <= 1'b0;
      if (ctrl_match) begin
        ctrl_q <= CtrlWord;
      end else if (CtrlValid) begin
        fwd_addr_q  <= CtrlAddr;
        fwd_word_q  <= CtrlWord;
        fwd_valid_q <= 1'b1;
      end
    end
  end

  // Pair assembly next-state: choose hold/A/B updates and the pair strobe.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    a_d       = a_q;
    b_d       = b_q;
    abvalid_d = 1'b0;
    if (flush) begin
      // Held word and any word accepted this cycle are dropped.
      state_d = ST_FIRST;
    end else if (accept) begin
      case (state_q)
        ST_FIRST: begin
          if (ctrl_q[`RB_INGRESSCTRL_DUP]) begin
            a_d       = IngressData;
            b_d       = IngressData;
            abvalid_d = 1'b1;
          end else begin
            hold_d  = IngressData;
            state_d = ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (ctrl_q[`RB_INGRESSCTRL_ORDER]) begin
            a_d = IngressData;
            b_d = hold_q;
          end else begin
            a_d = hold_q;
            b_d = IngressData;
          end
          abvalid_d = 1'b1;
          state_d   = ST_FIRST;
        end
        default: state_d = ST_FIRST;
      endcase
    end
  end

  // Pair assembly registers and the wrapping pair counter.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state_q   <= ST_FIRST;
      hold_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      abvalid_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      a_q       <= a_d;
      b_q       <= b_d;
      abvalid_q <= abvalid_d;
      if (abvalid_d) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign IngressReady = ctrl_q[`RB_INGRESSCTRL_INPUTEN];
  assign A            = a_q;
  assign B            = b_q;
  assign ABValid      = abvalid_q;
  assign PairCount    = count_q;
  assign CtrlAddrOut  = fwd_addr_q;
  assign CtrlWordOut  = fwd_word_q;
  assign CtrlValidOut = fwd_valid_q;

endmodule
